spi_flash_seq: RTL and testbench

Command sequencer for the SPI flash path: on a start pulse it drives one complete flash transaction (opcode, 24-bit address, 0–255 data bytes) through the SPI byte shifter. It moves data to or from the shared 32-bit transfer buffer through that buffer's SPI-side port. It sits between the Wishbone-side control registers (command source) and the buffer/SPI_MASTER pair. It owns chip-select framing, buffer addressing, byte packing and error abort.

---
 rtl/spi_seq_pkg.sv | 44 ++++
 rtl/spi_word_packer.sv | 45 ++++
 rtl/spi_flash_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
// Byte-lane helpers are used for both opcode/address emission and data packing.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPC   = 3'd1,
    ST_ADR   = 3'd2,
    ST_FETCH = 3'd3,
    ST_DATA  = 3'd4,
    ST_STORE = 3'd5,
    ST_CSHI  = 3'd6
  } seq_state_e;

  localparam int LEN_W       = 8;
  localparam int IDX_W       = 8;
  localparam int CS_GAP_DEF  = 2;
  localparam int ACK_TMO_DEF = 16;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;

  // Lane 0 is the most significant byte (big-endian order on the wire).
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = w[31:24];
      2'd1:    lane_byte = w[23:16];
      2'd2:    lane_byte = w[15:8];
      default: lane_byte = w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    lane_put = w;
    case (lane)
      2'd0:    lane_put[31:24] = b;
      2'd1:    lane_put[23:16] = b;
      2'd2:    lane_put[15:8]  = b;
      default: lane_put[7:0]   = b;
    endcase
  endfunction

endpackage

// File: rtl/spi_word_packer.sv
// 4-byte pack/unpack register with a byte-lane counter. Loads a fetched word for
// transmit, or accumulates received bytes MSB-first into a cleared word.
module spi_word_packer
  import spi_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [31:0] i_load_data,
  input  logic        i_step,
  input  logic        i_capture,
  input  logic [7:0]  i_rx_byte,
  output logic [31:0] o_word,
  output logic [7:0]  o_tx_byte,
  output logic [1:0]  o_lane
);

  logic [31:0] r_word;
  logic [1:0]  r_lane;

  // Word/lane register: clear, load and step are mutually exclusive in use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= 32'h0000_0000;
      r_lane <= 2'd0;
    end else if (i_clr) begin
      r_word <= 32'h0000_0000;
      r_lane <= 2'd0;
    end else if (i_load) begin
      r_word <= i_load_data;
      r_lane <= 2'd0;
    end else if (i_step) begin
      if (i_capture) begin
        r_word <= lane_put(r_word, r_lane, i_rx_byte);
      end
      r_lane <= r_lane + 2'd1;
    end
  end

  assign o_word    = r_word;
  assign o_tx_byte = lane_byte(r_word, r_lane);
  assign o_lane    = r_lane;

endmodule

// File: rtl/spi_flash_seq.sv
// SPI flash transaction sequencer: frames CS, emits opcode + 24-bit address, then
// streams data between the SPI byte shifter and the 32-bit transfer buffer.
module spi_flash_seq
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int CS_GAP  = CS_GAP_DEF,
  parameter int ACK_TMO = ACK_TMO_DEF
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  input  logic              START_I,
  input  logic [7:0]        OPCODE_I,
  input  logic [23:0]       FLASH_ADR_I,
  input  logic [7:0]        LEN_I,
  input  logic              DIR_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic              ERR_O,
  output logic [ADDR_W-1:0] BUF_ADR_O,
  output logic              BUF_WE_O,
  output logic              BUF_STB_O,
  output logic [31:0]       BUF_DAT_O,
  input  logic [31:0]       BUF_DAT_I,
  input  logic              BUF_ACK_I,
  output logic              SH_REQ_O,
  output logic [7:0]        SH_TX_O,
  input  logic [7:0]        SH_RX_I,
  input  logic              SH_ACK_I,
  output logic              SH_CS_N_O
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  seq_state_e        r_state, w_state_nxt;
  logic [7:0]        r_opcode;
  logic [23:0]       r_adr;
  logic [LEN_W-1:0]  r_len;
  logic              r_dir;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [1:0]        r_abyte, w_abyte_nxt;
  logic [ADDR_W-1:0] r_word, w_word_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic              r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
  logic              r_req, w_req_nxt, r_cs_n, w_cs_n_nxt;
  logic              r_stb, w_stb_nxt, r_we, w_we_nxt;
  logic [7:0]        r_tx, w_tx_nxt;
  logic [ADDR_W-1:0] r_badr, w_badr_nxt;
  logic [31:0]       r_bdat, w_bdat_nxt;
  logic              w_start, w_last;
  logic              w_pk_clr, w_pk_load, w_pk_step, w_pk_cap;
  logic [31:0]       w_pk_word;
  logic [7:0]        w_pk_tx;
  logic [1:0]        w_pk_lane;

  assign w_start = (r_state == ST_IDLE) && START_I;
  assign w_last  = (r_idx == (r_len - 8'd1));

  spi_word_packer u_packer (
    .i_clk       (CLK_I),
    .i_rst_n     (RST_N_I),
    .i_clr       (w_pk_clr),
    .i_load      (w_pk_load),
    .i_load_data (BUF_DAT_I),
    .i_step      (w_pk_step),
    .i_capture   (w_pk_cap),
    .i_rx_byte   (SH_RX_I),
    .o_word      (w_pk_word),
    .o_tx_byte   (w_pk_tx),
    .o_lane      (w_pk_lane)
  );

  // Command latch: captured only when a START is accepted in IDLE.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_opcode <= 8'h00;
      r_adr    <= 24'h00_0000;
      r_len    <= 8'h00;
      r_dir    <= 1'b0;
    end else if (w_start) begin
      r_opcode <= OPCODE_I;
      r_adr    <= FLASH_ADR_I;
      r_len    <= LEN_I;
      r_dir    <= DIR_I;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_abyte_nxt = r_abyte;
    w_word_nxt  = r_word;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    w_req_nxt   = r_req;
    w_tx_nxt    = r_tx;
    w_cs_n_nxt  = r_cs_n;
    w_stb_nxt   = r_stb;
    w_we_nxt    = r_we;
    w_badr_nxt  = r_badr;
    w_bdat_nxt  = r_bdat;
    w_pk_clr    = 1'b0;
    w_pk_load   = 1'b0;
    w_pk_step   = 1'b0;
    w_pk_cap    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START_I) begin
          w_state_nxt = ST_OPC;
          w_req_nxt   = 1'b1;
          w_tx_nxt    = OPCODE_I;
          w_cs_n_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_idx_nxt   = 8'd0;
          w_word_nxt  = '0;
          w_abyte_nxt = 2'd0;
          w_pk_clr    = 1'b1;
        end else begin
          w_cs_n_nxt  = 1'b1;
        end
      end
      ST_OPC: begin
        if (SH_ACK_I) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_ADR;
        end else begin
          w_req_nxt   = r_req;
        end
      end
      ST_ADR: begin
        if (!r_req) begin
          w_req_nxt = 1'b1;
          w_tx_nxt  = lane_byte({r_adr, 8'h00}, r_abyte);
        end else if (SH_ACK_I) begin
          w_req_nxt = 1'b0;
          if (r_abyte != 2'd2) begin
            w_abyte_nxt = r_abyte + 2'd1;
          end else if (r_len == 8'd0) begin
            w_state_nxt = ST_CSHI;
            w_cs_n_nxt  = 1'b1;
          end else begin
            w_state_nxt = r_dir ? ST_FETCH : ST_DATA;
          end
        end else begin
          w_req_nxt = r_req;
        end
      end
      ST_FETCH, ST_STORE: begin
        if (!r_stb) begin
          w_stb_nxt  = 1'b1;
          w_we_nxt   = (r_state == ST_STORE);
          w_badr_nxt = r_word;
          w_bdat_nxt = (r_state == ST_STORE) ? w_pk_word : r_bdat;
          w_tmo_nxt  = '0;
        end else if (BUF_ACK_I) begin
          w_stb_nxt  = 1'b0;
          w_we_nxt   = 1'b0;
          w_word_nxt = r_word + ADDR_W'(1);
          if (r_state == ST_FETCH) begin
            w_pk_load   = 1'b1;
            w_state_nxt = ST_DATA;
          end else if (r_idx == r_len) begin
            w_pk_clr    = 1'b1;
            w_state_nxt = ST_CSHI;
            w_cs_n_nxt  = 1'b1;
          end else begin
            w_pk_clr    = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end else if (r_tmo == TMO_LAST) begin
          // Buffer never answered: drop the request and close the frame cleanly.
          w_stb_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_CSHI;
          w_cs_n_nxt  = 1'b1;
        end else begin
          w_tmo_nxt   = r_tmo + TMO_W'(1);
        end
      end
      ST_DATA: begin
        if (!r_req) begin
          w_req_nxt = 1'b1;
          w_tx_nxt  = r_dir ? w_pk_tx : 8'h00;
        end else if (SH_ACK_I) begin
          w_req_nxt = 1'b0;
          w_pk_step = 1'b1;
          w_pk_cap  = !r_dir;
          w_idx_nxt = r_idx + 8'd1;
          if (r_dir && w_last) begin
            w_state_nxt = ST_CSHI;
            w_cs_n_nxt  = 1'b1;
          end else if (r_dir) begin
            w_state_nxt = (w_pk_lane == 2'd3) ? ST_FETCH : ST_DATA;
          end else begin
            w_state_nxt = (w_last || (w_pk_lane == 2'd3)) ? ST_STORE : ST_DATA;
          end
        end else begin
          w_req_nxt = r_req;
        end
      end
      ST_CSHI: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CSHI;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
        w_stb_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_cs_n_nxt  = 1'b1;
      end
    endcase
    w_gap_nxt  = ((r_state == ST_CSHI) && (w_state_nxt == ST_CSHI)) ? (r_gap + GAP_W'(1)) : '0;
    w_done_nxt = (w_state_nxt == ST_CSHI) && (w_gap_nxt == GAP_LAST);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; async reset drops CS and all strobes at once.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state <= ST_IDLE;
      r_idx   <= 8'd0;
      r_abyte <= 2'd0;
      r_word  <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_tx    <= 8'h00;
      r_cs_n  <= 1'b1;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_badr  <= '0;
      r_bdat  <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_abyte <= w_abyte_nxt;
      r_word  <= w_word_nxt;
      r_tmo   <= w_tmo_nxt;
      r_gap   <= w_gap_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_req   <= w_req_nxt;
      r_tx    <= w_tx_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_stb   <= w_stb_nxt;
      r_we    <= w_we_nxt;
      r_badr  <= w_badr_nxt;
      r_bdat  <= w_bdat_nxt;
    end
  end

  assign BUSY_O    = r_busy;
  assign DONE_O    = r_done;
  assign ERR_O     = r_err;
  assign BUF_ADR_O = r_badr;
  assign BUF_WE_O  = r_we;
  assign BUF_STB_O = r_stb;
  assign BUF_DAT_O = r_bdat;
  assign SH_REQ_O  = r_req;
  assign SH_TX_O   = r_tx;
  assign SH_CS_N_O = r_cs_n;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with behavioural SPI shifter and buffer models.
module tb_spi_flash_seq;
  import spi_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [23:0] fadr = 24'h0;
  logic [7:0]  len = 8'h00;
  logic        dir = 1'b0;
  logic        busy, done, err;
  logic [7:0]  buf_adr;
  logic        buf_we, buf_stb;
  logic [31:0] buf_dat_o;
  logic [31:0] buf_dat_i = 32'h0;
  logic        buf_ack = 1'b0;
  logic        sh_req;
  logic [7:0]  sh_tx;
  logic [7:0]  sh_rx = 8'h00;
  logic        sh_ack = 1'b0;
  logic        cs_n;

  logic [7:0]  tx_log [64];
  logic [7:0]  rx_tbl [32];
  logic [31:0] mem [64];
  int          tx_n = 0, rx_base = 0, sh_cnt = 0, n_rd = 0, n_wr = 0;
  logic        buf_hold = 1'b0, ld_en = 1'b0;
  logic [5:0]  ld_adr = 6'd0;
  logic [31:0] ld_dat = 32'h0;
  int          cyc = 0, done_cnt = 0, cs_run = 0, cs_run_at_done = 0;
  int          stb_rise_cyc = 0, err_rise_cyc = 0;
  logic        prev_stb = 1'b0, prev_err = 1'b0;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  spi_flash_seq dut (
    .CLK_I(clk), .RST_N_I(rst_n), .START_I(start), .OPCODE_I(opcode),
    .FLASH_ADR_I(fadr), .LEN_I(len), .DIR_I(dir), .BUSY_O(busy), .DONE_O(done),
    .ERR_O(err), .BUF_ADR_O(buf_adr), .BUF_WE_O(buf_we), .BUF_STB_O(buf_stb),
    .BUF_DAT_O(buf_dat_o), .BUF_DAT_I(buf_dat_i), .BUF_ACK_I(buf_ack),
    .SH_REQ_O(sh_req), .SH_TX_O(sh_tx), .SH_RX_I(sh_rx), .SH_ACK_I(sh_ack),
    .SH_CS_N_O(cs_n)
  );

  // Shifter model: acks each request after three cycles, logs TX, returns RX table bytes.
  always @(negedge clk) begin
    if (!rst_n) begin
      sh_ack <= 1'b0;
      sh_cnt <= 0;
    end else if (sh_req && !sh_ack) begin
      if (sh_cnt == 2) begin
        sh_ack <= 1'b1;
        sh_rx  <= rx_tbl[(tx_n - rx_base) & 31];
        tx_log[tx_n & 63] <= sh_tx;
        tx_n   <= tx_n + 1;
        sh_cnt <= 0;
      end else begin
        sh_cnt <= sh_cnt + 1;
      end
    end else begin
      sh_ack <= 1'b0;
    end
  end

  // Buffer model: one-cycle ack unless held off; counts reads and writes.
  always @(negedge clk) begin
    if (ld_en) mem[ld_adr] <= ld_dat;
    if (!rst_n) begin
      buf_ack <= 1'b0;
    end else if (buf_stb && !buf_ack && !buf_hold) begin
      buf_ack <= 1'b1;
      if (buf_we) begin
        mem[buf_adr[5:0]] <= buf_dat_o;
        n_wr <= n_wr + 1;
      end else begin
        buf_dat_i <= mem[buf_adr[5:0]];
        n_rd <= n_rd + 1;
      end
    end else begin
      buf_ack <= 1'b0;
    end
  end

  // Observers: done pulses, CS-high run length at DONE, STB/ERR rise times.
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_stb <= buf_stb;
    prev_err <= err;
    if (buf_stb && !prev_stb) stb_rise_cyc <= cyc;
    if (err && !prev_err) err_rise_cyc <= cyc;
    if (done) begin
      done_cnt       <= done_cnt + 1;
      cs_run_at_done <= (cs_n && busy) ? cs_run + 1 : 0;
    end
    if (cs_n && busy) cs_run <= cs_run + 1;
    else cs_run <= 0;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    step();
    ld_en = 1'b1; ld_adr = a; ld_dat = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic kick(input logic [7:0] op, input logic [23:0] a, input logic [7:0] l,
                      input logic d);
    step();
    start = 1'b1; opcode = op; fadr = a; len = l; dir = d;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_cnt == base && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) check_val(tag, 32'd0, 32'd1);
    repeat (3) step();
  endtask

  initial begin
    int bt, bd, br, bw, n;
    logic [7:0] exp_r [4];
    logic [7:0] exp_w [12];
    logic [7:0] exp_6 [4];
    exp_r = '{8'h03, 8'h12, 8'h34, 8'h56};
    exp_w = '{8'h02, 8'h0A, 8'h0B, 8'h0C, 8'hA1, 8'hB2, 8'hC3, 8'hD4,
              8'h01, 8'h02, 8'h03, 8'h04};
    exp_6 = '{8'h03, 8'hAB, 8'hCD, 8'hEF};
    for (int i = 0; i < 32; i++) rx_tbl[i] = 8'hEE;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    check_val("rst_flags", {25'd0, busy, done, err, sh_req, buf_stb, buf_we, cs_n}, 32'h1);
    check_val("rst_tx", {24'd0, sh_tx}, 32'h0);
    check_val("rst_badr", {24'd0, buf_adr}, 32'h0);
    check_val("rst_bdat", buf_dat_o, 32'h0);
    rst_n = 1'b1;
    step();

    // Read, 5 bytes: two stores, second word zero-padded.
    preload(6'd0, 32'hDEADBEEF);
    preload(6'd1, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) rx_tbl[4 + i] = 8'h11 + 8'(i);
    bt = tx_n; bd = done_cnt; br = n_rd; bw = n_wr; rx_base = tx_n;
    kick(OP_READ, 24'h123456, 8'd5, 1'b0);
    check_val("start_flags", {29'd0, busy, cs_n, sh_req}, 32'h5);
    check_val("start_tx", {24'd0, sh_tx}, 32'h03);
    wait_done(bd, "rd_timeout");
    for (int i = 0; i < 4; i++) check_val("rd_txbyte", {24'd0, tx_log[(bt + i) & 63]}, {24'd0, exp_r[i]});
    check_val("rd_txcount", tx_n - bt, 32'd9);
    check_val("rd_word0", mem[0], 32'h11121314);
    check_val("rd_word1", mem[1], 32'h15000000);
    check_val("rd_writes", n_wr - bw, 32'd2);
    check_val("rd_reads", n_rd - br, 32'd0);
    check_val("rd_done", done_cnt - bd, 32'd1);
    check_val("rd_cs_gap", cs_run_at_done, 32'd2);
    check_val("rd_err", {31'd0, err}, 32'd0);

    // Write, 8 bytes: two fetches, big-endian byte order.
    preload(6'd0, 32'hA1B2C3D4);
    preload(6'd1, 32'h01020304);
    bt = tx_n; bd = done_cnt; br = n_rd; bw = n_wr;
    kick(OP_PP, 24'h0A0B0C, 8'd8, 1'b1);
    wait_done(bd, "wr_timeout");
    check_val("wr_txcount", tx_n - bt, 32'd12);
    for (int i = 0; i < 12; i++) check_val("wr_txbyte", {24'd0, tx_log[(bt + i) & 63]}, {24'd0, exp_w[i]});
    check_val("wr_reads", n_rd - br, 32'd2);
    check_val("wr_writes", n_wr - bw, 32'd0);
    check_val("wr_done", done_cnt - bd, 32'd1);
    check_val("wr_cs_gap", cs_run_at_done, 32'd2);

    // Zero-length: header only, no buffer traffic.
    bt = tx_n; bd = done_cnt; br = n_rd; bw = n_wr;
    kick(8'h06, 24'hFFFFFF, 8'd0, 1'b1);
    wait_done(bd, "len0_timeout");
    check_val("len0_txcount", tx_n - bt, 32'd4);
    check_val("len0_lastbyte", {24'd0, tx_log[(bt + 3) & 63]}, 32'hFF);
    check_val("len0_bufacc", (n_rd - br) + (n_wr - bw), 32'd0);
    check_val("len0_done", done_cnt - bd, 32'd1);

    // Buffer never acks during FETCH: abort after ACK_TMO cycles.
    buf_hold = 1'b1;
    bt = tx_n; bd = done_cnt;
    kick(OP_PP, 24'h000000, 8'd4, 1'b1);
    wait_done(bd, "abort_timeout");
    check_val("abort_err", {31'd0, err}, 32'd1);
    check_val("abort_tmo", err_rise_cyc - stb_rise_cyc, 32'd16);
    check_val("abort_stb_cs", {30'd0, buf_stb, cs_n}, 32'h1);
    check_val("abort_done", done_cnt - bd, 32'd1);
    check_val("abort_txcount", tx_n - bt, 32'd4);
    buf_hold = 1'b0;
    bd = done_cnt;
    kick(OP_READ, 24'h000000, 8'd0, 1'b0);
    check_val("err_clear", {31'd0, err}, 32'd0);
    wait_done(bd, "clr_timeout");

    // Async reset while the second data byte is requested.
    preload(6'd0, 32'h5A5A5A5A);
    bt = tx_n;
    kick(OP_READ, 24'h000040, 8'd8, 1'b0);
    n = 0;
    while (!((tx_n - bt) == 5 && sh_req) && n < 500) begin
      step();
      n++;
    end
    check_val("rst_reach", {31'd0, sh_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_flags", {25'd0, busy, done, err, sh_req, buf_stb, buf_we, cs_n}, 32'h1);
    check_val("midrst_tx", {24'd0, sh_tx}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) rx_tbl[4 + i] = 8'h21 + 8'(i);
    bt = tx_n; bd = done_cnt; rx_base = tx_n;
    kick(OP_READ, 24'h000020, 8'd4, 1'b0);
    wait_done(bd, "post_rst_timeout");
    check_val("postrst_word0", mem[0], 32'h21222324);
    check_val("postrst_txcount", tx_n - bt, 32'd8);
    check_val("postrst_err", {31'd0, err}, 32'd0);

    // START while busy and in the DONE cycle is ignored.
    rx_tbl[4] = 8'h77;
    bt = tx_n; bd = done_cnt; rx_base = tx_n;
    kick(OP_READ, 24'hABCDEF, 8'd1, 1'b0);
    repeat (6) step();
    check_val("ign_busy", {31'd0, busy}, 32'd1);
    start = 1'b1; opcode = 8'h9F; fadr = 24'h111111; len = 8'd0; dir = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      step();
      n++;
    end
    check_val("ign_done_seen", {31'd0, done}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("ign_idle", {30'd0, busy, cs_n}, 32'h1);
    repeat (20) step();
    check_val("ign_busy_after", {31'd0, busy}, 32'd0);
    check_val("ign_txcount", tx_n - bt, 32'd5);
    for (int i = 0; i < 4; i++) check_val("ign_txbyte", {24'd0, tx_log[(bt + i) & 63]}, {24'd0, exp_6[i]});
    check_val("ign_word0", mem[0], 32'h77000000);
    check_val("ign_done", done_cnt - bd, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
